// File: rtl/ex_operand_stage_if.sv
// Bundle of ID-side, forwarding and EX-side signals around the ID/EX operand stage.
// The slave modport is the stage itself. The master modport is its environment.
interface ex_operand_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    // Decode side
    logic            i_id_valid;
    logic            o_id_ready;
    logic [XLEN-1:0] i_id_pc;
    logic [XLEN-1:0] i_id_rs1_data;
    logic [XLEN-1:0] i_id_rs2_data;
    logic [XLEN-1:0] i_id_imm;
    logic [RA_W-1:0] i_id_rs1;
    logic [RA_W-1:0] i_id_rs2;
    logic [RA_W-1:0] i_id_rd;
    logic [12:0]     i_id_ctrl;
    logic            i_flush;

    // Forwarding sources
    logic [RA_W-1:0] i_mem_rd;
    logic            i_mem_we;
    logic [XLEN-1:0] i_mem_data;
    logic [RA_W-1:0] i_wb_rd;
    logic            i_wb_we;
    logic [XLEN-1:0] i_wb_data;

    // EX side
    logic            o_ex_valid;
    logic            i_ex_ready;
    logic [XLEN-1:0] o_op_a;
    logic [XLEN-1:0] o_op_b;
    logic [3:0]      o_op_sel;
    logic [1:0]      o_bool_op;
    logic            o_sub;
    logic            o_shift_dir;
    logic            o_cmp_sig;
    logic [XLEN-1:0] o_ex_pc;
    logic [RA_W-1:0] o_ex_rd;
    logic            o_ex_reg_we;
    logic            o_ex_is_load;
    logic [XLEN-1:0] o_ex_store_data;

    modport slave (
        input  i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
        input  i_id_rs1, i_id_rs2, i_id_rd, i_id_ctrl, i_flush,
        input  i_mem_rd, i_mem_we, i_mem_data, i_wb_rd, i_wb_we, i_wb_data,
        input  i_ex_ready,
        output o_id_ready, o_ex_valid, o_op_a, o_op_b, o_op_sel, o_bool_op,
        output o_sub, o_shift_dir, o_cmp_sig, o_ex_pc, o_ex_rd, o_ex_reg_we,
        output o_ex_is_load, o_ex_store_data
    );

    modport master (
        output i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
        output i_id_rs1, i_id_rs2, i_id_rd, i_id_ctrl, i_flush,
        output i_mem_rd, i_mem_we, i_mem_data, i_wb_rd, i_wb_we, i_wb_data,
        output i_ex_ready,
        input  o_id_ready, o_ex_valid, o_op_a, o_op_b, o_op_sel, o_bool_op,
        input  o_sub, o_shift_dir, o_cmp_sig, o_ex_pc, o_ex_rd, o_ex_reg_we,
        input  o_ex_is_load, o_ex_store_data
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble, flush, and MEM/WB operand forwarding.
// Presents ALU operands and registered control fields to EX under a valid/ready handshake.
module ex_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    ex_operand_stage_if.slave   bus
);

    // Bit positions inside the 13-bit control word
    localparam int unsigned CtrlRegWe   = 0;
    localparam int unsigned CtrlIsLoad  = 1;
    localparam int unsigned CtrlBSelImm = 2;
    localparam int unsigned CtrlASelPc  = 3;
    localparam int unsigned CtrlCmpSig  = 4;
    localparam int unsigned CtrlShDir   = 5;
    localparam int unsigned CtrlSub     = 6;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [12:0]     ctrl_q, ctrl_d;

    logic            advance;
    logic            load_use;
    logic            accept;
    logic            wb_hit_id_rs1, wb_hit_id_rs2;
    logic            wb_hit_q_rs1, wb_hit_q_rs2;
    logic            mem_hit_q_rs1, mem_hit_q_rs2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // Handshake and hazard detection
    always_comb begin
        advance  = ~valid_q | bus.i_ex_ready;
        load_use = valid_q & ctrl_q[CtrlIsLoad] & (rd_q != '0) &
                   ((rd_q == bus.i_id_rs1) | (rd_q == bus.i_id_rs2));
        accept   = advance & bus.i_id_valid & ~load_use & ~bus.i_flush;
    end

    // Write-back hits, both against the offered sources and the held sources
    always_comb begin
        wb_hit_id_rs1 = bus.i_wb_we & (bus.i_wb_rd != '0) & (bus.i_wb_rd == bus.i_id_rs1);
        wb_hit_id_rs2 = bus.i_wb_we & (bus.i_wb_rd != '0) & (bus.i_wb_rd == bus.i_id_rs2);
        wb_hit_q_rs1  = bus.i_wb_we & (bus.i_wb_rd != '0) & (bus.i_wb_rd == rs1_q);
        wb_hit_q_rs2  = bus.i_wb_we & (bus.i_wb_rd != '0) & (bus.i_wb_rd == rs2_q);
        mem_hit_q_rs1 = bus.i_mem_we & (bus.i_mem_rd != '0) & (bus.i_mem_rd == rs1_q);
        mem_hit_q_rs2 = bus.i_mem_we & (bus.i_mem_rd != '0) & (bus.i_mem_rd == rs2_q);
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;

        if (bus.i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            pc_d       = bus.i_id_pc;
            // WB retires in the same cycle the regfile is read, so its value is newer
            rs1_data_d = wb_hit_id_rs1 ? bus.i_wb_data : bus.i_id_rs1_data;
            rs2_data_d = wb_hit_id_rs2 ? bus.i_wb_data : bus.i_id_rs2_data;
            imm_d      = bus.i_id_imm;
            rs1_d      = bus.i_id_rs1;
            rs2_d      = bus.i_id_rs2;
            rd_d       = bus.i_id_rd;
            ctrl_d     = bus.i_id_ctrl;
        end else if (advance) begin
            valid_d = 1'b0;
        end else begin
            // Stalled: capture values retiring past us so they survive the stall
            if (wb_hit_q_rs1) begin
                rs1_data_d = bus.i_wb_data;
            end
            if (wb_hit_q_rs2) begin
                rs2_data_d = bus.i_wb_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        fwd_rs1 = mem_hit_q_rs1 ? bus.i_mem_data :
                  wb_hit_q_rs1  ? bus.i_wb_data  : rs1_data_q;
        fwd_rs2 = mem_hit_q_rs2 ? bus.i_mem_data :
                  wb_hit_q_rs2  ? bus.i_wb_data  : rs2_data_q;
    end

    always_comb begin
        bus.o_id_ready      = advance & ~load_use & ~bus.i_flush;
        bus.o_ex_valid      = valid_q;
        bus.o_op_a          = ctrl_q[CtrlASelPc]  ? pc_q  : fwd_rs1;
        bus.o_op_b          = ctrl_q[CtrlBSelImm] ? imm_q : fwd_rs2;
        bus.o_ex_store_data = fwd_rs2;
        bus.o_op_sel        = ctrl_q[12:9];
        bus.o_bool_op       = ctrl_q[8:7];
        bus.o_sub           = ctrl_q[CtrlSub];
        bus.o_shift_dir     = ctrl_q[CtrlShDir];
        bus.o_cmp_sig       = ctrl_q[CtrlCmpSig];
        bus.o_ex_pc         = pc_q;
        bus.o_ex_rd         = rd_q;
        bus.o_ex_reg_we     = ctrl_q[CtrlRegWe];
        bus.o_ex_is_load    = ctrl_q[CtrlIsLoad];
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, operand select, forwarding priority,
// backpressure with WB refresh, load-use bubble, flush, and asynchronous reset.
module tb_ex_operand_stage;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_errors;

    ex_operand_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [12:0] mk_ctrl(input logic [3:0] op, input logic [1:0] bo,
                                            input logic sub, input logic sd, input logic cs,
                                            input logic apc, input logic bimm,
                                            input logic ld, input logic we);
        return {op, bo, sub, sd, cs, apc, bimm, ld, we};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [12:0] ctrl);
        bus.i_id_valid    = 1'b1;
        bus.i_id_pc       = pc;
        bus.i_id_rs1      = rs1;
        bus.i_id_rs1_data = d1;
        bus.i_id_rs2      = rs2;
        bus.i_id_rs2_data = d2;
        bus.i_id_imm      = imm;
        bus.i_id_rd       = rd;
        bus.i_id_ctrl     = ctrl;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst_n  = 1'b0;
        bus.i_id_valid = 1'b0;
        bus.i_id_pc = '0; bus.i_id_rs1_data = '0; bus.i_id_rs2_data = '0; bus.i_id_imm = '0;
        bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rd = '0; bus.i_id_ctrl = '0;
        bus.i_flush = 1'b0;
        bus.i_mem_rd = '0; bus.i_mem_we = 1'b0; bus.i_mem_data = '0;
        bus.i_wb_rd = '0; bus.i_wb_we = 1'b0; bus.i_wb_data = '0;
        bus.i_ex_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("rst_op_a", bus.o_op_a, 32'h0);
        chk("rst_pc", bus.o_ex_pc, 32'h0);
        chk("rst_id_ready", 32'(bus.o_id_ready), 32'd1);
        #10;
        i_rst_n = 1'b1;
        step();
        chk("post_rst_no_valid", 32'(bus.o_ex_valid), 32'd0);

        // Operand select: pc / immediate, controls passthrough
        offer(32'h100, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 32'hFFFF_FFFC, 5'd9,
              mk_ctrl(4'b0001, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        chk("sel_id_ready", 32'(bus.o_id_ready), 32'd1);
        step();
        bus.i_id_valid = 1'b0;
        chk("sel_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("sel_op_a", bus.o_op_a, 32'h100);
        chk("sel_op_b", bus.o_op_b, 32'hFFFF_FFFC);
        chk("sel_op_sel", 32'(bus.o_op_sel), 32'h1);
        chk("sel_bool_op", 32'(bus.o_bool_op), 32'h2);
        chk("sel_sub", 32'(bus.o_sub), 32'h0);
        chk("sel_shift_dir", 32'(bus.o_shift_dir), 32'h1);
        chk("sel_cmp_sig", 32'(bus.o_cmp_sig), 32'h1);
        chk("sel_rd", 32'(bus.o_ex_rd), 32'd9);
        chk("sel_reg_we", 32'(bus.o_ex_reg_we), 32'h1);
        chk("sel_is_load", 32'(bus.o_ex_is_load), 32'h0);
        chk("sel_store_data", bus.o_ex_store_data, 32'hBBBB);

        // Back-to-back accept, then forwarding priority on held rs1=x5
        offer(32'h104, 5'd5, 32'h11, 5'd6, 32'h44, 32'h0, 5'd10,
              mk_ctrl(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        chk("b2b_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("b2b_rd", 32'(bus.o_ex_rd), 32'd10);
        bus.i_mem_rd = 5'd5; bus.i_mem_we = 1'b1; bus.i_mem_data = 32'h22;
        bus.i_wb_rd = 5'd5;  bus.i_wb_we = 1'b1;  bus.i_wb_data = 32'h33;
        #1;
        chk("fwd_mem_wins", bus.o_op_a, 32'h22);
        chk("fwd_op_b_plain", bus.o_op_b, 32'h44);
        chk("held_id_ready", 32'(bus.o_id_ready), 32'd0);
        bus.i_mem_we = 1'b0;
        #1;
        chk("fwd_wb", bus.o_op_a, 32'h33);
        bus.i_mem_we = 1'b1; bus.i_mem_rd = 5'd0; bus.i_wb_rd = 5'd0;
        #1;
        chk("fwd_x0_stored", bus.o_op_a, 32'h11);
        bus.i_mem_we = 1'b0; bus.i_wb_we = 1'b0;
        step();
        chk("hold_op_a", bus.o_op_a, 32'h11);

        // Backpressure: WB writes x3 only in the first stalled cycle
        bus.i_ex_ready = 1'b1;
        offer(32'h108, 5'd1, 32'h1000, 5'd3, 32'h5555, 32'h0, 5'd4,
              mk_ctrl(4'b0010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        bus.i_wb_rd = 5'd3; bus.i_wb_we = 1'b1; bus.i_wb_data = 32'hDEAD;
        #1;
        chk("bp_c1_op_b", bus.o_op_b, 32'hDEAD);
        step();
        bus.i_wb_we = 1'b0;
        #1;
        chk("bp_c2_op_b", bus.o_op_b, 32'hDEAD);
        chk("bp_c2_op_a", bus.o_op_a, 32'h1000);
        chk("bp_c2_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("bp_c2_rd", 32'(bus.o_ex_rd), 32'd4);
        chk("bp_c2_sub", 32'(bus.o_sub), 32'd1);
        step();
        chk("bp_c3_op_b", bus.o_op_b, 32'hDEAD);
        chk("bp_c3_pc", bus.o_ex_pc, 32'h108);
        step();
        bus.i_ex_ready = 1'b1;
        #1;
        chk("bp_rel_op_b", bus.o_op_b, 32'hDEAD);
        chk("bp_rel_store", bus.o_ex_store_data, 32'hDEAD);
        chk("bp_rel_valid", 32'(bus.o_ex_valid), 32'd1);
        step();
        chk("bp_drain", 32'(bus.o_ex_valid), 32'd0);

        // Load-use: lw x7 in EX, add x8,x7,x1 offered
        offer(32'h10C, 5'd2, 32'h2000, 5'd0, 32'h0, 32'h4, 5'd7,
              mk_ctrl(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        step();
        offer(32'h110, 5'd7, 32'h700, 5'd1, 32'h10, 32'h0, 5'd8,
              mk_ctrl(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        #1;
        chk("lu_is_load", 32'(bus.o_ex_is_load), 32'd1);
        chk("lu_id_ready", 32'(bus.o_id_ready), 32'd0);
        step();
        chk("lu_bubble", 32'(bus.o_ex_valid), 32'd0);
        chk("lu_id_ready_after", 32'(bus.o_id_ready), 32'd1);
        bus.i_wb_rd = 5'd7; bus.i_wb_we = 1'b1; bus.i_wb_data = 32'h77;
        step();
        bus.i_wb_we = 1'b0;
        bus.i_id_valid = 1'b0;
        #1;
        chk("lu_accept_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("lu_accept_rd", 32'(bus.o_ex_rd), 32'd8);
        chk("lu_capture_wb", bus.o_op_a, 32'h77);
        chk("lu_op_b", bus.o_op_b, 32'h10);

        // Flush with an offered instruction and advance=1
        offer(32'h114, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd11,
              mk_ctrl(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        bus.i_flush = 1'b1;
        #1;
        chk("flush_id_ready", 32'(bus.o_id_ready), 32'd0);
        step();
        bus.i_flush = 1'b0;
        bus.i_id_valid = 1'b0;
        chk("flush_valid", 32'(bus.o_ex_valid), 32'd0);

        // Reset mid-handshake
        offer(32'h200, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd12,
              mk_ctrl(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        chk("mid_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("mid_op_a", bus.o_op_a, 32'h200);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("mid_rst_op_a", bus.o_op_a, 32'h0);
        #2;
        i_rst_n = 1'b1;
        bus.i_ex_ready = 1'b1;
        step();
        chk("mid_rel_no_valid", 32'(bus.o_ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
